demux: RTL

- Deserializer for the FFT datapath. Takes the time-multiplexed sample stream produced by the 16:1 output multiplexer and rebuilds the 16 parallel words d1..d16.
- Runs a free-running frame counter aligned to the transmitter's 42-cycle frame.
- Captures slots 25..40 into a shadow bank, then commits all 16 words to the outputs at once with a one-cycle valid pulse.
- Sits at the input of the next FFT stage, or in the testbench, on the far side of the serial link.

---
 rtl/demux.sv | 135 +++++++++++++
 1 files changed

// File: rtl/demux.sv
// Frame deserializer: rebuilds 16 parallel words from the time-multiplexed sample stream
// using a free-running frame counter, a shadow bank and a single commit edge.
module demux #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned FRAME_LEN  = 42,
   parameter int unsigned FIRST_SLOT = 25
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [DATA_W-1:0] din,
   input  logic                     sync_in,
   output logic signed [DATA_W-1:0] d1,
   output logic signed [DATA_W-1:0] d2,
   output logic signed [DATA_W-1:0] d3,
   output logic signed [DATA_W-1:0] d4,
   output logic signed [DATA_W-1:0] d5,
   output logic signed [DATA_W-1:0] d6,
   output logic signed [DATA_W-1:0] d7,
   output logic signed [DATA_W-1:0] d8,
   output logic signed [DATA_W-1:0] d9,
   output logic signed [DATA_W-1:0] d10,
   output logic signed [DATA_W-1:0] d11,
   output logic signed [DATA_W-1:0] d12,
   output logic signed [DATA_W-1:0] d13,
   output logic signed [DATA_W-1:0] d14,
   output logic signed [DATA_W-1:0] d15,
   output logic signed [DATA_W-1:0] d16,
   output logic                     dout_valid,
   output logic                     sync_err,
   output logic [7:0]               frame_cnt
);

   localparam int unsigned NWORDS = 16;
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] SLOT_PRE   = CNT_W'(FIRST_SLOT - 1);
   localparam logic [CNT_W-1:0] SLOT_BASE  = CNT_W'(FIRST_SLOT);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(FIRST_SLOT + NWORDS - 1);

   typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT} state_t;

   state_t                     state, state_nxt;
   logic [CNT_W-1:0]           count, count_nxt;
   logic [IDX_W-1:0]           slot_idx;
   logic                       cap_en_c, commit_c, abort_c;
   logic signed [DATA_W-1:0]   shadow [NWORDS];
   logic signed [DATA_W-1:0]   dreg   [NWORDS];

   assign slot_idx = IDX_W'(count - SLOT_BASE);

   // Frame counter: sync_in overrides the normal wrap
   always_comb begin
      count_nxt = count + CNT_W'(1);
      if (sync_in || count == CNT_LAST) count_nxt = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
      end
   end

   // Next-state and control decode; sync_in during CAPTURE aborts the frame
   always_comb begin
      state_nxt = state;
      cap_en_c  = 1'b0;
      commit_c  = 1'b0;
      abort_c   = 1'b0;
      case (state)
         IDLE: begin
            if (!sync_in && count == SLOT_PRE) state_nxt = CAPTURE;
         end
         CAPTURE: begin
            if (sync_in) begin
               abort_c   = 1'b1;
               state_nxt = IDLE;
            end else begin
               cap_en_c = 1'b1;
               if (count == SLOT_LAST) begin
                  commit_c  = 1'b1;
                  state_nxt = COMMIT;
               end
            end
         end
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Shadow capture and parallel commit; the last word bypasses the shadow bank
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NWORDS; i++) begin
            shadow[i] <= '0;
            dreg[i]   <= '0;
         end
         dout_valid <= 1'b0;
         sync_err   <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         if (cap_en_c) shadow[slot_idx] <= din;
         if (commit_c) begin
            for (int i = 0; i < NWORDS - 1; i++) dreg[i] <= shadow[i];
            dreg[NWORDS-1] <= din;
         end
         dout_valid <= commit_c;
         sync_err   <= abort_c;
         frame_cnt  <= frame_cnt + 8'(commit_c);
      end
   end

   assign d1  = dreg[0];
   assign d2  = dreg[1];
   assign d3  = dreg[2];
   assign d4  = dreg[3];
   assign d5  = dreg[4];
   assign d6  = dreg[5];
   assign d7  = dreg[6];
   assign d8  = dreg[7];
   assign d9  = dreg[8];
   assign d10 = dreg[9];
   assign d11 = dreg[10];
   assign d12 = dreg[11];
   assign d13 = dreg[12];
   assign d14 = dreg[13];
   assign d15 = dreg[14];
   assign d16 = dreg[15];

endmodule
